// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT stage controller.
package ntt_pkg;

  localparam int N_LOG = 8;

  localparam logic [1:0] BF_NTT    = 2'b00;
  localparam logic [1:0] BF_INTT   = 2'b01;
  localparam logic [1:0] BF_BYPASS = 2'b10;
  localparam logic [1:0] BF_IDLE   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address map: (stage, butterfly index, direction)
// to operand addresses and twiddle-ROM address.
module ntt_addr_gen #(
  parameter int N_LOG = ntt_pkg::N_LOG
) (
  input  logic [$clog2(N_LOG)-1:0] s,
  input  logic [N_LOG-2:0]         j,
  input  logic                     inv,
  output logic [N_LOG-1:0]         rd_addr_a,
  output logic [N_LOG-1:0]         rd_addr_b,
  output logic [N_LOG-1:0]         tw_addr
);
  import ntt_pkg::*;

  localparam int SW = $clog2(N_LOG);
  localparam logic [N_LOG:0] ONE    = {{N_LOG{1'b0}}, 1'b1};
  localparam logic [SW:0]    LAST_S = (SW+1)'(N_LOG - 1);
  localparam logic [SW:0]    NL     = (SW+1)'(N_LOG);

  logic [SW:0]    s_w;
  logic [SW:0]    sh;
  logic [N_LOG:0] jw;
  logic [N_LOG:0] len;
  logic [N_LOG:0] g;
  logic [N_LOG:0] o;

  // Half-span is a power of two, so j/len and j%len reduce to shift and mask.
  always_comb begin
    s_w       = {1'b0, s};
    sh        = inv ? s_w : (LAST_S - s_w);
    jw        = {2'b00, j};
    len       = ONE << sh;
    g         = jw >> sh;
    o         = jw & (len - ONE);
    rd_addr_a = N_LOG'(((g << sh) << 1) | o);
    rd_addr_b = N_LOG'((((g << sh) << 1) | o) + len);
    if (inv) begin
      tw_addr = N_LOG'((ONE << (NL - s_w)) - ONE - g);
    end else begin
      tw_addr = N_LOG'((ONE << s_w) + g);
    end
  end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT stage sequencer: issues butterfly reads stage by stage, waits for the
// pipeline to drain between stages, and delays write-back strobes/addresses.
module ntt_ctrl #(
  parameter int N_LOG  = ntt_pkg::N_LOG,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inv,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [N_LOG-1:0] rd_addr_a,
  output logic [N_LOG-1:0] rd_addr_b,
  output logic [N_LOG-1:0] tw_addr,
  output logic             tw_neg,
  output logic [1:0]       bf_mode,
  output logic             wr_en,
  output logic [N_LOG-1:0] wr_addr_a,
  output logic [N_LOG-1:0] wr_addr_b
);
  import ntt_pkg::*;

  localparam int SW = $clog2(N_LOG);
  localparam int D  = RD_LAT + BF_LAT;
  localparam int DW = $clog2(D + 1);
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG - 1);
  localparam logic [DW-1:0] D_LAST = DW'(D - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    s;
  logic [N_LOG-2:0] j;
  logic [DW-1:0]    drain_cnt;
  logic             inv_q;
  logic [N_LOG-1:0] gen_a;
  logic [N_LOG-1:0] gen_b;
  logic [N_LOG-1:0] gen_tw;
  logic [D-1:0]     vld_pipe;
  logic [N_LOG-1:0] wa_pipe [D];
  logic [N_LOG-1:0] wb_pipe [D];

  ntt_addr_gen #(.N_LOG(N_LOG)) u_addr_gen (
    .s         (s),
    .j         (j),
    .inv       (inv_q),
    .rd_addr_a (gen_a),
    .rd_addr_b (gen_b),
    .tw_addr   (gen_tw)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (&j) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == D_LAST) state_nxt = (s == S_LAST) ? DONE : ISSUE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Butterfly/stage/drain counters and the direction latched at start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s         <= '0;
      j         <= '0;
      drain_cnt <= '0;
      inv_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            inv_q     <= inv;
            s         <= '0;
            j         <= '0;
            drain_cnt <= '0;
          end
        end
        ISSUE: j <= j + 1'b1;
        DRAIN: begin
          if (drain_cnt == D_LAST) begin
            drain_cnt <= '0;
            s         <= s + 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Delay line matching read latency plus butterfly latency for write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < D; i++) begin
        wa_pipe[i] <= '0;
        wb_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_en;
      wa_pipe[0]  <= rd_addr_a;
      wb_pipe[0]  <= rd_addr_b;
      for (int i = 1; i < D; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        wa_pipe[i]  <= wa_pipe[i-1];
        wb_pipe[i]  <= wb_pipe[i-1];
      end
    end
  end

  assign rd_addr_a = rd_en ? gen_a  : '0;
  assign rd_addr_b = rd_en ? gen_b  : '0;
  assign tw_addr   = rd_en ? gen_tw : '0;
  assign tw_neg    = rd_en & inv_q;
  assign bf_mode   = vld_pipe[RD_LAT-1] ? (inv_q ? BF_INTT : BF_NTT) : BF_IDLE;
  assign wr_en     = vld_pipe[D-1];
  assign wr_addr_a = wa_pipe[D-1];
  assign wr_addr_b = wb_pipe[D-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: cycle model, write-back scoreboard,
// spot-address table and mid-run reset.
module tb_ntt_ctrl;

  localparam int N_LOG  = 8;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 6;
  localparam int D      = RD_LAT + BF_LAT;
  localparam int BFLY   = 128;
  localparam int STAGES = 8;
  localparam int P      = BFLY + D;
  localparam int DONE_K = STAGES * P + 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic       inv;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [7:0] tw_addr;
  logic       tw_neg;
  logic [1:0] bf_mode;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;

  int tests = 0;
  int fails = 0;
  int obs_a  [2][STAGES][BFLY];
  int obs_b  [2][STAGES][BFLY];
  int obs_tw [2][STAGES][BFLY];

  typedef struct {
    bit iv;
    int s;
    int j;
    int a;
    int b;
    int tw;
  } vec_t;

  typedef struct {
    int due;
    int a;
    int b;
  } wr_t;

  localparam logic [46:0] RESET_VEC = {5'b0, 2'b11, 40'b0};

  ntt_ctrl #(.N_LOG(N_LOG), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inv       (inv),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .tw_neg    (tw_neg),
    .bf_mode   (bf_mode),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [46:0] out_vec();
    return {busy, done, rd_en, wr_en, tw_neg, bf_mode,
            rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b};
  endfunction

  // Reference for cycle k after acceptance (k = 1 is the first issue cycle).
  task automatic model(input int k, input bit iv, output bit en,
                       output int s, output int j, output int a, output int b, output int tw);
    int len, g, o;
    en = 0; s = 0; j = 0; a = 0; b = 0; tw = 0;
    if (k >= 1) begin
      s = (k - 1) / P;
      j = (k - 1) % P;
      if (s < STAGES && j < BFLY) begin
        en  = 1;
        len = iv ? (1 << s) : (BFLY >> s);
        g   = j / len;
        o   = j % len;
        a   = 2 * len * g + o;
        b   = a + len;
        tw  = iv ? ((256 >> s) - 1 - g) : ((1 << s) + g);
      end
    end
  endtask

  // One transform; abort_k > 0 pulls reset in that cycle, poke_k > 0 pulses start mid-run.
  task automatic applyStimulus(input bit iv, input int abort_k, input int poke_k);
    wr_t q[$];
    int  wcnt [256];
    int  rd_n = 0, wr_n = 0, done_n = 0, done_k = -1, st1_k = -1;
    bit  en, pen;
    int  s, j, a, b, tw, ps, pj, pa, pb, ptw, bad;
    bit  ew;
    int  ewa, ewb;
    logic [29:0] act_rd, exp_rd;
    logic [16:0] act_wr, exp_wr;

    foreach (wcnt[i]) wcnt[i] = 0;
    @(negedge clk);
    start = 1'b1;
    inv   = iv;
    @(posedge clk);
    #1 start = 1'b0;

    for (int k = 1; k <= DONE_K + 2; k++) begin
      if (k == abort_k) begin
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("reset outputs at k=%0d", k), 64'(out_vec()), 64'(RESET_VEC));
        repeat (3) begin
          @(negedge clk);
          checkOutput("reset hold quiet", 64'({busy, done, rd_en, wr_en}), 64'(0));
        end
        rst = 1'b1;
        return;
      end
      @(negedge clk);
      if (poke_k > 0 && k == poke_k + 1) begin
        start = 1'b0;
        inv   = iv;
      end

      model(k, iv, en, s, j, a, b, tw);
      model(k - 1, iv, pen, ps, pj, pa, pb, ptw);
      exp_rd = {(k >= 1 && k <= DONE_K), (k == DONE_K), en,
                (pen ? {1'b0, iv} : 2'b11), en & iv,
                (en ? 8'(a) : 8'd0), (en ? 8'(b) : 8'd0), (en ? 8'(tw) : 8'd0)};
      act_rd = {busy, done, rd_en, bf_mode, (rd_en ? tw_neg : 1'b0),
                (rd_en ? rd_addr_a : 8'd0), (rd_en ? rd_addr_b : 8'd0),
                (rd_en ? tw_addr : 8'd0)};
      checkOutput($sformatf("rd side k=%0d", k), 64'(act_rd), 64'(exp_rd));

      ew = (q.size() > 0) && (q[0].due == k);
      ewa = ew ? q[0].a : 0;
      ewb = ew ? q[0].b : 0;
      if (ew) void'(q.pop_front());
      exp_wr = {ew, 8'(ewa), 8'(ewb)};
      act_wr = {wr_en, (wr_en ? wr_addr_a : 8'd0), (wr_en ? wr_addr_b : 8'd0)};
      checkOutput($sformatf("wr side k=%0d", k), 64'(act_wr), 64'(exp_wr));
      if (en) q.push_back('{due: k + D, a: a, b: b});

      if (rd_en) begin
        rd_n++;
        if (rd_n == BFLY + 1) st1_k = k;
        if (en) begin
          obs_a[iv][s][j]  = int'(rd_addr_a);
          obs_b[iv][s][j]  = int'(rd_addr_b);
          obs_tw[iv][s][j] = int'(tw_addr);
        end
      end
      if (wr_en) begin
        wr_n++;
        wcnt[wr_addr_a]++;
        wcnt[wr_addr_b]++;
        if (wr_n % BFLY == 0) begin
          bad = 0;
          foreach (wcnt[i]) if (wcnt[i] != 1) bad++;
          checkOutput($sformatf("stage %0d addresses written once", wr_n / BFLY - 1),
                      64'(bad), 64'(0));
          foreach (wcnt[i]) wcnt[i] = 0;
        end
      end
      if (done) begin
        done_n++;
        done_k = k;
      end
      if (k == poke_k) begin
        start = 1'b1;
        inv   = ~iv;
      end
    end

    checkOutput("rd_en count", 64'(rd_n), 64'(STAGES * BFLY));
    checkOutput("wr_en count", 64'(wr_n), 64'(STAGES * BFLY));
    checkOutput("stage 1 first rd cycle", 64'(st1_k), 64'(136));
    checkOutput("done cycle", 64'(done_k), 64'(1081));
    checkOutput("done width", 64'(done_n), 64'(1));
    checkOutput("scoreboard empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{iv: 0, s: 0, j: 0,   a: 0,   b: 128, tw: 1};
    vecs[1] = '{iv: 0, s: 0, j: 127, a: 127, b: 255, tw: 1};
    vecs[2] = '{iv: 0, s: 7, j: 5,   a: 10,  b: 11,  tw: 133};
    vecs[3] = '{iv: 0, s: 3, j: 37,  a: 69,  b: 85,  tw: 10};
    vecs[4] = '{iv: 1, s: 0, j: 0,   a: 0,   b: 1,   tw: 255};
    vecs[5] = '{iv: 1, s: 7, j: 0,   a: 0,   b: 128, tw: 1};
    vecs[6] = '{iv: 1, s: 2, j: 9,   a: 17,  b: 21,  tw: 61};

    foreach (obs_a[x, y, z]) begin
      obs_a[x][y][z]  = -1;
      obs_b[x][y][z]  = -1;
      obs_tw[x][y][z] = -1;
    end

    rst   = 1'b0;
    start = 1'b0;
    inv   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("power-on reset outputs", 64'(out_vec()), 64'(RESET_VEC));
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 0, 50);
    applyStimulus(1'b1, 0, 700);
    applyStimulus(1'b0, 300, 0);
    applyStimulus(1'b0, 0, 0);

    for (int v = 0; v < 7; v++) begin
      checkOutput($sformatf("vec %0d addr a", v),
                  64'(obs_a[vecs[v].iv][vecs[v].s][vecs[v].j]), 64'(vecs[v].a));
      checkOutput($sformatf("vec %0d addr b", v),
                  64'(obs_b[vecs[v].iv][vecs[v].s][vecs[v].j]), 64'(vecs[v].b));
      checkOutput($sformatf("vec %0d twiddle", v),
                  64'(obs_tw[vecs[v].iv][vecs[v].s][vecs[v].j]), 64'(vecs[v].tw));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
